kbd_in_ctrl: RTL

Keyboard input controller for the PicoComputer CPU input port. It takes decoded PS/2 set-2 scancode bytes, assembles a decimal number from digit keys, and sequences the CPU `control`/`status` input handshake to deliver that number on `in`. It sits between the PS/2 receiver and `cpu` and replaces the direct button/switch drive of `control` and `in`. The receiver, this block and `cpu` share one clock domain.

---
 rtl/kbd_in_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/kbd_in_ctrl.sv
// kbd_in_ctrl: turns PS/2 set-2 scancodes into a decimal entry and delivers it
// to the CPU input port through the control/status handshake.
module kbd_in_ctrl #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MAX_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  code_valid,
   input  logic [7:0]            code,
   input  logic                  status,
   output logic                  control,
   output logic [DATA_WIDTH-1:0] in,
   output logic [DATA_WIDTH-1:0] buf_val,
   output logic [2:0]            digit_cnt,
   output logic                  busy
);

   localparam int unsigned CNT_W = 3;

   localparam logic [7:0] CODE_BRK   = 8'hF0;
   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_BKSP  = 8'h66;
   localparam logic [7:0] CODE_ENTER = 8'h5A;

   typedef enum logic [1:0] {
      S_EDIT  = 2'd0,
      S_WAIT  = 2'd1,
      S_OFFER = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_q;
   logic                  brk_q;
   logic                  ext_q;
   logic [DATA_WIDTH-1:0] buf_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] in_q;
   logic                  control_q;
   logic                  busy_q;

   logic                  make_c;
   logic                  is_digit_c;
   logic [3:0]            digit_c;
   logic [DATA_WIDTH-1:0] buf_push_c;
   logic [DATA_WIDTH-1:0] buf_pop_c;

   // Map a scancode to its decimal digit value.
   always_comb begin
      is_digit_c = 1'b1;
      digit_c    = 4'd0;
      case (code)
         8'h45:   digit_c = 4'd0;
         8'h16:   digit_c = 4'd1;
         8'h1E:   digit_c = 4'd2;
         8'h26:   digit_c = 4'd3;
         8'h25:   digit_c = 4'd4;
         8'h2E:   digit_c = 4'd5;
         8'h36:   digit_c = 4'd6;
         8'h3D:   digit_c = 4'd7;
         8'h3E:   digit_c = 4'd8;
         8'h46:   digit_c = 4'd9;
         default: is_digit_c = 1'b0;
      endcase
   end

   // A make code is a non-prefix byte that carries no pending break/extended flag.
   assign make_c     = code_valid && (code != CODE_BRK) && (code != CODE_EXT)
                       && !brk_q && !ext_q;
   assign buf_push_c = DATA_WIDTH'(buf_q * DATA_WIDTH'(10)) + DATA_WIDTH'(digit_c);
   assign buf_pop_c  = buf_q / DATA_WIDTH'(10);

   // Prefix tracking, buffer editing and the CPU handshake sequencer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_EDIT;
         brk_q     <= 1'b0;
         ext_q     <= 1'b0;
         buf_q     <= '0;
         cnt_q     <= '0;
         in_q      <= '0;
         control_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         if (code_valid) begin
            if (code == CODE_BRK) begin
               brk_q <= 1'b1;
            end else if (code == CODE_EXT) begin
               ext_q <= 1'b1;
            end else begin
               brk_q <= 1'b0;
               ext_q <= 1'b0;
            end
         end

         case (state_q)
            S_EDIT: begin
               control_q <= 1'b0;
               busy_q    <= 1'b0;
               if (make_c) begin
                  if (is_digit_c) begin
                     if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                        buf_q <= buf_push_c;
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end else if (code == CODE_BKSP) begin
                     if (cnt_q != '0) begin
                        buf_q <= buf_pop_c;
                        cnt_q <= cnt_q - CNT_W'(1);
                     end
                  end else if (code == CODE_ENTER) begin
                     if (cnt_q != '0) begin
                        in_q    <= buf_q;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                     end
                  end
               end
            end
            S_WAIT: begin
               if (status) begin
                  control_q <= 1'b1;
                  state_q   <= S_OFFER;
               end
            end
            S_OFFER: begin
               if (!status) begin
                  control_q <= 1'b0;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               buf_q   <= '0;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= S_EDIT;
            end
            default: state_q <= S_EDIT;
         endcase
      end
   end

   assign control   = control_q;
   assign in        = in_q;
   assign buf_val   = buf_q;
   assign digit_cnt = cnt_q;
   assign busy      = busy_q;

endmodule
